// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/bit-count ops plus multi-cycle
// shift-add multiply and restoring unsigned divide/remainder.
package custom_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_CTZ  = 4'd10;
  localparam logic [3:0] ALU_CLZ  = 4'd11;
  localparam logic [3:0] ALU_CPOP = 4'd12;
  localparam logic [3:0] ALU_MUL  = 4'd13;
  localparam logic [3:0] ALU_DIVU = 4'd14;
  localparam logic [3:0] ALU_REMU = 4'd15;
endpackage

module iter_alu
  import custom_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      sel_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sel_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] acc_q;   // product accumulator / partial remainder
  logic [XLEN-1:0] opa_q;   // multiplicand / dividend shifting into quotient
  logic [XLEN-1:0] opb_q;   // multiplier / divisor
  logic [XLEN-1:0] result_q;

  logic            accept, iter_op, last_iter;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] single_res, iter_res;
  logic [XLEN-1:0] mul_acc_nxt, div_rem_nxt, div_quo_nxt;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ok;

  function automatic logic [XLEN-1:0] f_ctz(input logic [XLEN-1:0] v);
    f_ctz = XLEN'(XLEN);
    for (int i = XLEN - 1; i >= 0; i--) if (v[i]) f_ctz = XLEN'(i);
  endfunction

  function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] v);
    f_clz = XLEN'(XLEN);
    for (int i = 0; i < XLEN; i++) if (v[i]) f_clz = XLEN'(XLEN - 1 - i);
  endfunction

  function automatic logic [XLEN-1:0] f_cpop(input logic [XLEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < XLEN; i++) n += int'(v[i]);
    f_cpop = XLEN'(n);
  endfunction

  // kill_i in IDLE blocks the accept rather than being ignored outright.
  assign ready_o   = (state_q == IDLE);
  assign accept    = valid_i && ready_o && !kill_i;
  assign iter_op   = (sel_i == ALU_MUL) || (sel_i == ALU_DIVU) || (sel_i == ALU_REMU);
  assign last_iter = (state_q == BUSY) && (cnt_q == SHW'(XLEN - 1));
  assign valid_o   = (state_q == DONE) && !kill_i;
  assign result_o  = result_q;
  assign sh        = op2_i[SHW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = iter_op ? BUSY : DONE;
      BUSY: begin
        if (kill_i)         state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    single_res = '0;
    case (sel_i)
      ALU_ADD:  single_res = op1_i + op2_i;
      ALU_SUB:  single_res = op1_i - op2_i;
      ALU_SLL:  single_res = op1_i << sh;
      ALU_SRL:  single_res = op1_i >> sh;
      ALU_SRA:  single_res = $signed(op1_i) >>> sh;
      ALU_SLT:  single_res = XLEN'($signed(op1_i) < $signed(op2_i));
      ALU_SLTU: single_res = XLEN'(op1_i < op2_i);
      ALU_XOR:  single_res = op1_i ^ op2_i;
      ALU_OR:   single_res = op1_i | op2_i;
      ALU_AND:  single_res = op1_i & op2_i;
      ALU_CTZ:  single_res = f_ctz(op1_i);
      ALU_CLZ:  single_res = f_clz(op1_i);
      ALU_CPOP: single_res = f_cpop(op1_i);
      default:  single_res = '0;
    endcase
  end

  // One multiply step (LSB first) and one restoring-division step (MSB first).
  always_comb begin
    mul_acc_nxt = opb_q[0] ? acc_q + opa_q : acc_q;
    div_shift   = {acc_q, opa_q[XLEN-1]};
    div_diff    = div_shift - {1'b0, opb_q};
    div_ok      = !div_diff[XLEN];
    div_rem_nxt = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_nxt = {opa_q[XLEN-2:0], div_ok};
    iter_res    = div_rem_nxt;
    if (sel_q == ALU_MUL)       iter_res = mul_acc_nxt;
    else if (sel_q == ALU_DIVU) iter_res = div_quo_nxt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      sel_q <= sel_i;
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= op1_i;
      opb_q <= op2_i;
      if (!iter_op) result_q <= single_res;
    end else if (state_q == BUSY && !kill_i) begin
      cnt_q <= cnt_q + SHW'(1);
      if (sel_q == ALU_MUL) begin
        acc_q <= mul_acc_nxt;
        opa_q <= {opa_q[XLEN-2:0], 1'b0};
        opb_q <= {1'b0, opb_q[XLEN-1:1]};
      end else begin
        acc_q <= div_rem_nxt;
        opa_q <= div_quo_nxt;
      end
      if (last_iter) result_q <= iter_res;
    end
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived localparam SHW = $clog2(XLEN), meaning shift-amount and iteration-counter width.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  request strobe; sel_i/op1_i/op2_i valid while high.
REQ-006 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-007 SHALL have port sel_i  input  4  operation select, ALU_* encodings from custom_pkg.
REQ-008 SHALL have port op1_i  input  XLEN  first operand / dividend / multiplicand.
REQ-009 SHALL have port op2_i  input  XLEN  second operand / divisor / multiplier / shift amount.
REQ-010 SHALL have port kill_i  input  1  abort any in-flight operation.
REQ-011 SHALL have port valid_o  output  1  one-cycle pulse, result_o valid.
REQ-012 SHALL have port result_o  output  XLEN  registered result.

Function
REQ-013 SHALL add custom_pkg codes ALU_MUL=4'd13, ALU_DIVU=4'd14, ALU_REMU=4'd15; existing ALU_* codes keep their values.
REQ-014 SHALL accept a request on a rising edge where valid_i && ready_o, latching sel_i, op1_i, op2_i.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = (state==IDLE) only.
REQ-016 SHALL transition IDLE->DONE on accept of any single-cycle op; IDLE->BUSY on accept of MUL/DIVU/REMU; BUSY->DONE when iteration counter reaches XLEN-1; DONE->IDLE unconditionally.
REQ-017 SHALL assert valid_o exactly in DONE; result_o registered and held stable until the next result is written.
REQ-018 SHALL give single-cycle ops latency 1: accept at edge N, valid_o high in cycle N+1, ready_o high again at N+2.
REQ-019 SHALL give MUL/DIVU/REMU latency XLEN+1: accept at edge N, XLEN BUSY cycles, valid_o high in cycle N+XLEN+1.
REQ-020 SHALL compute single-cycle ops: ADD, SUB, OR, AND, XOR modulo 2^XLEN; SLL/SRL/SRA use op2[SHW-1:0]; SLT signed, SLTU unsigned, result zero-extended 0/1.
REQ-021 SHALL compute CTZ/CLZ/CPOP over XLEN bits, result zero-extended; CTZ(0)=CLZ(0)=XLEN.
REQ-022 SHALL compute MUL as low XLEN bits of op1*op2 by radix-2 shift-add, one bit per BUSY cycle, LSB first.
REQ-023 SHALL compute DIVU/REMU by restoring division, one quotient bit per BUSY cycle, MSB first.
REQ-024 SHALL return for divisor 0: DIVU = all ones, REMU = op1; still take full XLEN+1 latency.
REQ-025 SHALL return 0 with latency 1 for any undefined sel_i.
REQ-026 SHALL, on kill_i high in BUSY or DONE, go to IDLE next edge, suppress valid_o in that cycle onward, leave result_o unchanged.
REQ-027 SHALL ignore kill_i in IDLE; kill_i and valid_i together in IDLE: request is NOT accepted.
REQ-028 SHALL ignore valid_i, sel_i, op1_i, op2_i while ready_o is low; latched operands unaffected.
REQ-029 SHALL reset iteration counter to 0 on every accept.

Reset
REQ-030 SHALL, on rst_i high at a rising edge, enter IDLE, clear counter and datapath registers, drive ready_o=1, valid_o=0, result_o=0 the following cycle.
REQ-031 SHALL give rst_i priority over kill_i and valid_i; reset mid-BUSY discards the operation with no valid_o.

Verification
REQ-032 SHALL cover: XLEN=32, ADD 0xFFFFFFFF+1 -> valid_o one cycle after accept, result 0x00000000; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-033 SHALL cover: MUL 0x0001_0003 * 0x0000_0005 -> valid_o 33 cycles after accept, result 0x0005_000F, ready_o low for 33 cycles.
REQ-034 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-035 SHALL cover: kill_i at BUSY cycle 10 of DIVU -> no valid_o, ready_o high next cycle, result_o keeps previous value; next ADD 2+3 -> 5.
REQ-036 SHALL cover: rst_i mid-MUL -> next cycle ready_o=1, valid_o=0, result_o=0; CTZ(0) -> 32, CPOP(0xF0F0F0F0) -> 16.
REQ-037 SHALL cover: XLEN=8, MUL 0x10*0x10 -> 0x00 at latency 9; CLZ(0x01) -> 7.
